// File: rtl/apuracao_votos_if.sv
// Purpose: bundles the vote-tally control, vote input and result signals.
// Latency: none, wires only.
// Backpressure: none; voter and requester use 1-cycle strobes, the tally uses ocupado.
interface apuracao_votos_if #(
    parameter int N_JOG = 5,
    parameter int W_JOG = 3,
    parameter int W_CNT = 3
);
    logic             zera;
    logic             voto_valido;
    logic [W_JOG-1:0] jogador_escolhido;
    logic [N_JOG-1:0] vivos;
    logic             apurar;
    logic             ocupado;
    logic             pronto;
    logic [W_JOG-1:0] eliminado;
    logic             empate;
    logic [W_CNT-1:0] total_votos;

    // Driver side: player-input logic / game FSM.
    modport master (
        output zera, voto_valido, jogador_escolhido, vivos, apurar,
        input  ocupado, pronto, eliminado, empate, total_votos
    );

    // Tally side.
    modport slave (
        input  zera, voto_valido, jogador_escolhido, vivos, apurar,
        output ocupado, pronto, eliminado, empate, total_votos
    );
endinterface

// File: rtl/apuracao_votos.sv
// Purpose: counts day-phase votes and, on apurar, picks the player to eliminate or PULAR.
// Latency: apurar at edge E -> pronto after edge E+N_JOG+2, one cycle wide.
// Backpressure: none; votes and apurar are dropped while ocupado is high.
module apuracao_votos #(
    parameter int N_JOG = 5,
    parameter int W_JOG = 3,
    parameter int PULAR = 5,
    parameter int W_CNT = 3
) (
    input  logic              clock,
    input  logic              rst_global_n,
    apuracao_votos_if.slave   bus
);

    localparam logic [W_JOG-1:0] L_N_JOG = W_JOG'(N_JOG);
    localparam logic [W_JOG-1:0] L_PULAR = W_JOG'(PULAR);
    localparam logic [W_CNT-1:0] L_SAT   = W_CNT'(N_JOG);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        VARRE   = 2'd1,
        RESOLVE = 2'd2
    } estado_t;

    estado_t          r_estado;
    logic [W_CNT-1:0] r_cont [N_JOG];
    logic [W_CNT-1:0] r_cont_pular;
    logic [W_CNT-1:0] r_total;
    logic [W_CNT-1:0] r_max;
    logic [W_JOG-1:0] r_idx;
    logic [W_JOG-1:0] r_cand;
    logic [W_JOG-1:0] r_eliminado;
    logic             r_empate_int;
    logic             r_empate;
    logic             r_pronto;
    logic             r_ocupado;

    logic             w_alvo_vivo;
    logic             w_alvo_pular;
    logic             w_conta;
    logic [W_CNT-1:0] w_cont_idx;

    // A vote only counts for a live, in-range player or the explicit skip code.
    assign w_alvo_vivo  = (bus.jogador_escolhido < L_N_JOG) && bus.vivos[bus.jogador_escolhido];
    assign w_alvo_pular = (bus.jogador_escolhido == L_PULAR);
    assign w_conta      = (r_estado == OCIOSO) && bus.voto_valido && (w_alvo_vivo || w_alvo_pular);
    // r_idx reaches N_JOG on the hand-off cycle; the value read then is never used.
    assign w_cont_idx   = r_cont[r_idx];

    // Tally counters, scan FSM and registered results; zera behaves like a synchronous reset.
    always_ff @(posedge clock or negedge rst_global_n) begin
        if (!rst_global_n) begin
            r_estado     <= OCIOSO;
            for (int i = 0; i < N_JOG; i++) r_cont[i] <= '0;
            r_cont_pular <= '0;
            r_total      <= '0;
            r_max        <= '0;
            r_idx        <= '0;
            r_cand       <= L_PULAR;
            r_eliminado  <= L_PULAR;
            r_empate_int <= 1'b0;
            r_empate     <= 1'b0;
            r_pronto     <= 1'b0;
            r_ocupado    <= 1'b0;
        end else if (bus.zera) begin
            r_estado     <= OCIOSO;
            for (int i = 0; i < N_JOG; i++) r_cont[i] <= '0;
            r_cont_pular <= '0;
            r_total      <= '0;
            r_max        <= '0;
            r_idx        <= '0;
            r_cand       <= L_PULAR;
            r_eliminado  <= L_PULAR;
            r_empate_int <= 1'b0;
            r_empate     <= 1'b0;
            r_pronto     <= 1'b0;
            r_ocupado    <= 1'b0;
        end else begin
            r_pronto <= 1'b0;

            // Counting is gated to OCIOSO inside w_conta; all counters stop at N_JOG.
            if (w_conta) begin
                if (r_total != L_SAT) r_total <= r_total + W_CNT'(1);
                if (w_alvo_pular) begin
                    if (r_cont_pular != L_SAT) r_cont_pular <= r_cont_pular + W_CNT'(1);
                end else begin
                    for (int i = 0; i < N_JOG; i++) begin
                        if ((bus.jogador_escolhido == W_JOG'(i)) && (r_cont[i] != L_SAT))
                            r_cont[i] <= r_cont[i] + W_CNT'(1);
                    end
                end
            end

            case (r_estado)
                OCIOSO: begin
                    if (bus.apurar) begin
                        r_estado     <= VARRE;
                        r_idx        <= '0;
                        r_max        <= '0;
                        r_empate_int <= 1'b0;
                        r_cand       <= L_PULAR;
                        r_ocupado    <= 1'b1;
                    end
                end
                VARRE: begin
                    // One player per cycle; the cycle with r_idx==N_JOG hands off to RESOLVE.
                    if (r_idx < L_N_JOG) begin
                        if (w_cont_idx > r_max) begin
                            r_max        <= w_cont_idx;
                            r_cand       <= r_idx;
                            r_empate_int <= 1'b0;
                        end else if ((w_cont_idx == r_max) && (r_max != '0)) begin
                            r_empate_int <= 1'b1;
                        end
                        r_idx <= r_idx + W_JOG'(1);
                    end else begin
                        r_estado <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    // Skip wins on no votes, a tie, or when skips reach the top count.
                    if ((r_max == '0) || r_empate_int || (r_cont_pular >= r_max))
                        r_eliminado <= L_PULAR;
                    else
                        r_eliminado <= r_cand;
                    r_empate  <= r_empate_int;
                    r_pronto  <= 1'b1;
                    r_ocupado <= 1'b0;
                    r_estado  <= OCIOSO;
                end
                default: begin
                    r_estado  <= OCIOSO;
                    r_ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ocupado     = r_ocupado;
    assign bus.pronto      = r_pronto;
    assign bus.eliminado   = r_eliminado;
    assign bus.empate      = r_empate;
    assign bus.total_votos = r_total;

endmodule

// File: tb/tb_apuracao_votos.sv
// Purpose: randomized and directed stimulus for apuracao_votos with a queue-based scoreboard.
// Latency: expects pronto exactly N_JOG+2 edges after apurar is sampled.
// Backpressure: stimulus waits for each scan result before issuing more votes.
module tb_apuracao_votos;

    localparam int N = 5;
    localparam int P = 5;

    logic clock;
    logic rst_global_n;
    int   cyc;
    int   n_tests;
    int   n_fail;

    apuracao_votos_if #(.N_JOG(N), .W_JOG(3), .W_CNT(3)) bus ();

    apuracao_votos #(.N_JOG(N), .W_JOG(3), .PULAR(P), .W_CNT(3)) dut (
        .clock        (clock),
        .rst_global_n (rst_global_n),
        .bus          (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int elim;
        int emp;
        int tot;
        int cyc;
    } exp_t;

    exp_t q[$];

    // Reference tallies: plain integers, saturating at N.
    int       m_cnt [N];
    int       m_pular;
    int       m_total;
    bit [4:0] m_vivos;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_pular = 0;
        m_total = 0;
    endtask

    task automatic model_vote(input int j);
        if (j < N && m_vivos[j]) begin
            if (m_cnt[j] < N) m_cnt[j]++;
            if (m_total < N) m_total++;
        end else if (j == P) begin
            if (m_pular < N) m_pular++;
            if (m_total < N) m_total++;
        end
    endtask

    // Expected result from the rules: top count, how many share it, skip comparison.
    task automatic model_push(input int cyc_exp);
        int   mx;
        int   nmax;
        int   arg;
        exp_t e;
        mx = 0; nmax = 0; arg = 0;
        for (int i = 0; i < N; i++) if (m_cnt[i] > mx) mx = m_cnt[i];
        for (int i = N - 1; i >= 0; i--) begin
            if (mx > 0 && m_cnt[i] == mx) begin
                nmax++;
                arg = i;
            end
        end
        e.emp  = (nmax > 1) ? 1 : 0;
        e.elim = (mx == 0 || nmax > 1 || m_pular >= mx) ? P : arg;
        e.tot  = m_total;
        e.cyc  = cyc_exp;
        q.push_back(e);
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic set_vivos(input bit [4:0] v);
        m_vivos   = v;
        bus.vivos = v;
    endtask

    task automatic vote(input int j);
        bus.voto_valido       = 1'b1;
        bus.jogador_escolhido = 3'(j);
        model_vote(j);
        step();
        bus.voto_valido = 1'b0;
    endtask

    task automatic do_zera();
        bus.zera = 1'b1;
        model_clear();
        step();
        bus.zera = 1'b0;
    endtask

    task automatic wait_results();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 40) begin
            step();
            guard++;
        end
        chk("result_timeout", q.size(), 0);
        q.delete();
        step();
    endtask

    // Starts a scan (any vote already on the bus is counted in the same cycle).
    task automatic run_scan();
        bus.apurar = 1'b1;
        model_push(cyc + 8);
        step();
        bus.apurar      = 1'b0;
        bus.voto_valido = 1'b0;
        chk("ocupado_after_apurar", int'(bus.ocupado), 1);
        wait_results();
    endtask

    // Scoreboard monitor: every pronto must match the oldest expectation.
    always @(negedge clock) begin
        if (rst_global_n && bus.pronto) begin
            if (q.size() == 0) begin
                chk("unexpected_pronto", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("eliminado",   int'(bus.eliminado),   e.elim);
                chk("empate",      int'(bus.empate),      e.emp);
                chk("total_votos", int'(bus.total_votos), e.tot);
                chk("pronto_cycle", cyc,                  e.cyc);
                chk("ocupado_at_pronto", int'(bus.ocupado), 0);
            end
        end
    end

    task automatic check_idle_cleared(input string tag);
        chk({tag, "_ocupado"},   int'(bus.ocupado),     0);
        chk({tag, "_pronto"},    int'(bus.pronto),      0);
        chk({tag, "_eliminado"}, int'(bus.eliminado),   P);
        chk({tag, "_empate"},    int'(bus.empate),      0);
        chk({tag, "_total"},     int'(bus.total_votos), 0);
    endtask

    // Start a scan, then disturb it on the third VARRE cycle.
    task automatic abort_scan(input bit use_reset);
        bus.apurar = 1'b1;
        step();
        bus.apurar = 1'b0;
        step();
        step();
        if (use_reset) rst_global_n = 1'b0;
        else           bus.zera     = 1'b1;
        model_clear();
        step();
        rst_global_n = 1'b1;
        bus.zera     = 1'b0;
        check_idle_cleared(use_reset ? "abort_rst" : "abort_zera");
        repeat (12) step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_global_n          = 1'b0;
        bus.zera              = 1'b0;
        bus.voto_valido       = 1'b0;
        bus.jogador_escolhido = '0;
        bus.apurar            = 1'b0;
        set_vivos(5'b11111);
        model_clear();
        repeat (3) step();
        check_idle_cleared("reset");
        rst_global_n = 1'b1;
        step();

        // T1: clear winner, then a second scan with votes arriving while busy.
        vote(2); vote(2); vote(0);
        run_scan();
        bus.apurar = 1'b1;
        model_push(cyc + 8);
        step();
        bus.apurar = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.voto_valido       = 1'b1;
            bus.jogador_escolhido = 3'd0;
            bus.apurar            = (k == 2);
            step();
        end
        bus.voto_valido = 1'b0;
        bus.apurar      = 1'b0;
        wait_results();
        chk("busy_votes_ignored_total", int'(bus.total_votos), 3);

        // Results hold until zera clears them.
        do_zera();
        check_idle_cleared("zera");

        // T2: tie.
        vote(1); vote(3); vote(1); vote(3);
        run_scan();

        // T3: skip versus top count.
        do_zera();
        vote(4); vote(5); vote(5);
        run_scan();
        do_zera();
        vote(4); vote(4); vote(5);
        run_scan();

        // T4: dead target and out-of-range codes, then an empty tally.
        do_zera();
        set_vivos(5'b11011);
        vote(2); vote(6); vote(7); vote(0);
        run_scan();
        do_zera();
        run_scan();

        // T5: saturation.
        do_zera();
        set_vivos(5'b11111);
        for (int k = 0; k < 7; k++) vote(1);
        chk("sat_total", int'(bus.total_votos), 5);
        run_scan();

        // Vote and apurar in the same cycle.
        do_zera();
        vote(3);
        bus.voto_valido       = 1'b1;
        bus.jogador_escolhido = 3'd3;
        model_vote(3);
        run_scan();

        // T6: aborts.
        do_zera();
        vote(1); vote(1);
        abort_scan(1'b0);
        vote(2);
        abort_scan(1'b1);

        // Randomized rounds, sometimes accumulating across scans.
        for (int r = 0; r < 30; r++) begin
            int nv;
            if ($urandom_range(0, 1) == 0) do_zera();
            set_vivos(5'($urandom_range(0, 31)));
            nv = $urandom_range(0, 8);
            for (int k = 0; k < nv; k++) vote($urandom_range(0, 7));
            run_scan();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
